// File: rtl/tone_scheduler_if.sv
// Note submission channel into the tone scheduler.
// The sequencer drives a note and the scheduler answers with ready.
interface tone_scheduler_if #(
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 16
);
    logic                note_valid;
    logic                note_ready;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur;

    modport master (
        output note_valid,
        output note_period,
        output note_dur,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note_period,
        input  note_dur,
        output note_ready
    );
endinterface

// File: rtl/tone_scheduler.sv
// Plays queued notes: strobes sin_clk at each note's period for its duration
// and pulses phase_rst as every note starts.
module tone_scheduler #(
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             reset,
    tone_scheduler_if.slave  note,
    input  logic             stop,
    output logic             sin_clk,
    output logic             phase_rst,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] pc_q, pc_d;
    logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PERIOD_W-1:0] per_mem_q [DEPTH];
    logic [PERIOD_W-1:0] per_mem_d [DEPTH];
    logic [DUR_W-1:0]    dur_mem_q [DEPTH];
    logic [DUR_W-1:0]    dur_mem_d [DEPTH];

    logic             push;
    logic             pop;
    logic [DUR_W-1:0] head_dur;
    logic             at_wrap;

    assign note.note_ready = (count_q < CNT_W'(DEPTH));
    assign fifo_count      = count_q;
    assign busy            = (state_q != IDLE);
    assign phase_rst       = (state_q == LOAD);
    assign at_wrap         = (pc_q == period_q - PERIOD_W'(1));
    assign sin_clk         = (state_q == PLAY) && (period_q != '0) && at_wrap;

    assign push     = note.note_valid && note.note_ready && !stop;
    assign pop      = (state_q == LOAD);
    assign head_dur = dur_mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        pc_d      = pc_q;
        dur_cnt_d = dur_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        per_mem_d = per_mem_q;
        dur_mem_d = dur_mem_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            per_mem_d[wr_ptr_q] = note.note_period;
            dur_mem_d[wr_ptr_q] = note.note_dur;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                period_d  = per_mem_q[rd_ptr_q];
                dur_cnt_d = (head_dur == '0) ? DUR_W'(1) : head_dur;
                pc_d      = '0;
                state_d   = PLAY;
            end
            PLAY: begin
                dur_cnt_d = dur_cnt_q - DUR_W'(1);
                // A rest keeps pc parked at zero so it never decodes a strobe.
                if (period_q == '0 || at_wrap) begin
                    pc_d = '0;
                end else begin
                    pc_d = pc_q + PERIOD_W'(1);
                end
                if (dur_cnt_q == DUR_W'(1)) begin
                    state_d = (count_q != '0) ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop) begin
            state_d   = IDLE;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pc_d      = '0;
            dur_cnt_d = '0;
            period_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            period_q  <= '0;
            pc_q      <= '0;
            dur_cnt_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            pc_q      <= pc_d;
            dur_cnt_q <= dur_cnt_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            per_mem_q <= per_mem_d;
            dur_mem_q <= dur_mem_d;
        end
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// Randomised scoreboard bench for tone_scheduler against a note-timeline model.
module tb_tone_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       stop;
    logic       sin_clk;
    logic       phase_rst;
    logic       busy;
    logic [2:0] fifo_count;

    tone_scheduler_if #(.PERIOD_W(16), .DUR_W(16)) nif ();

    tone_scheduler #(
        .PERIOD_W(16),
        .DUR_W(16),
        .DEPTH(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .note(nif.slave),
        .stop(stop),
        .sin_clk(sin_clk),
        .phase_rst(phase_rst),
        .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int push_c;
        int start_c;
        int end_c;
        int flush_c;
        bit dead;
    } note_t;

    typedef struct {
        int c;
        bit k;  // 1 = phase_rst, 0 = sin_clk
    } ev_t;

    note_t notes[$];
    ev_t   evq[$];
    int    cyc = 0;
    int    last_end = -10;
    bit    mon_en = 1'b0;
    int    vec = 0;
    int    errs = 0;

    function automatic int m_count(int c);
        int n = 0;
        foreach (notes[i])
            if (notes[i].push_c < c && notes[i].start_c >= c && c <= notes[i].flush_c)
                n++;
        return n;
    endfunction

    function automatic bit m_busy(int c);
        foreach (notes[i])
            if (!notes[i].dead && notes[i].start_c <= c && c <= notes[i].end_c)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic take(bit k);
        vec++;
        if (evq.size() == 0 || evq[0].c != cyc || evq[0].k != k) begin
            errs++;
            $display("FAIL %s cyc=%0d got=pulse expected_next=%0d",
                     k ? "phase_rst" : "sin_clk", cyc,
                     evq.size() ? evq[0].c : -1);
        end
        if (evq.size() > 0 && evq[0].c == cyc)
            void'(evq.pop_front());
    endtask

    // One stimulus cycle: drive inputs, update the model, advance the clock.
    task automatic step(input bit v, input int p, input int d,
                        input bit s, input bit r);
        bit    kill;
        int    de;
        note_t n;
        ev_t   e;
        logic [31:0] pv, dv;
        pv = p;
        dv = d;
        nif.note_valid  = v;
        nif.note_period = pv[15:0];
        nif.note_dur    = dv[15:0];
        stop  = s;
        reset = r;
        kill  = s || r;
        if (v && !kill && m_count(cyc) < 4) begin
            de = (d == 0) ? 1 : d;
            n.push_c  = cyc;
            n.start_c = (cyc + 2 > last_end + 1) ? cyc + 2 : last_end + 1;
            n.end_c   = n.start_c + de;
            n.flush_c = 32'h7fff_ffff;
            n.dead    = 1'b0;
            notes.push_back(n);
            last_end = n.end_c;
            e.c = n.start_c;
            e.k = 1'b1;
            evq.push_back(e);
            if (p > 0)
                for (int k = 1; k * p <= de; k++) begin
                    e.c = n.start_c + k * p;
                    e.k = 1'b0;
                    evq.push_back(e);
                end
        end
        if (kill) begin
            foreach (notes[i]) begin
                if (!notes[i].dead) begin
                    if (notes[i].start_c > cyc) begin
                        notes[i].dead    = 1'b1;
                        notes[i].flush_c = cyc;
                    end else if (notes[i].end_c > cyc) begin
                        notes[i].end_c = cyc;
                    end
                end
            end
            while (evq.size() > 0 && evq[$].c > cyc)
                void'(evq.pop_back());
            if (last_end > cyc)
                last_end = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("fifo_count", 32'(fifo_count), 32'(m_count(cyc)));
            chk("busy", 32'(busy), 32'(m_busy(cyc)));
            chk("note_ready", 32'(nif.note_ready), 32'(m_count(cyc) < 4));
            while (evq.size() > 0 && evq[0].c < cyc) begin
                vec++;
                errs++;
                $display("FAIL missed_%s cyc=%0d got=none expected_at=%0d",
                         evq[0].k ? "phase_rst" : "sin_clk", cyc, evq[0].c);
                void'(evq.pop_front());
            end
            if (phase_rst === 1'b1) take(1'b1);
            if (sin_clk === 1'b1) take(1'b0);
        end
    end

    initial begin
        int vprob;
        int p;
        int d;
        reset = 1'b1;
        stop  = 1'b0;
        nif.note_valid  = 1'b0;
        nif.note_period = '0;
        nif.note_dur    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        cyc    = 0;
        mon_en = 1'b1;
        #4;
        chk("reset_ready", 32'(nif.note_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_sin_clk", 32'(sin_clk), 32'd0);
        chk("reset_phase_rst", 32'(phase_rst), 32'd0);
        #1;

        step(1, 4, 10, 0, 0);
        repeat (15) step(0, 0, 0, 0, 0);
        step(1, 3, 6, 0, 0);
        step(1, 2, 4, 0, 0);
        repeat (16) step(0, 0, 0, 0, 0);
        step(1, 0, 5, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 3, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (20) step(1, 5, 40, 0, 0);
        step(1, 2, 3, 1, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        repeat (3) step(1, 2, 50, 0, 0);
        repeat (17) step(0, 0, 0, 0, 0);
        step(1, 2, 50, 1, 0);
        repeat (10) step(0, 0, 0, 0, 0);

        vprob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: vprob = 20;
                    1: vprob = 60;
                    default: vprob = 95;
                endcase
            end
            case ($urandom_range(0, 5))
                0: p = 0;
                1: p = 1;
                2: p = 2;
                default: p = $urandom_range(3, 9);
            endcase
            case ($urandom_range(0, 4))
                0: d = 0;
                1: d = 1;
                default: d = $urandom_range(2, 25);
            endcase
            step($urandom_range(0, 99) < vprob, p, d,
                 $urandom_range(0, 149) == 0, i == 1500);
        end

        for (int i = 0; i < 2000; i++) begin
            if (evq.size() == 0 && !m_busy(cyc) && m_count(cyc) == 0)
                break;
            step(0, 0, 0, 0, 0);
        end
        repeat (3) step(0, 0, 0, 0, 0);
        chk("drain_pending", 32'(evq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
